// File: rtl/twiddle_pkg.sv
// Shared definitions for the twiddle sequencer: formats, FSM states, and the
// constant functions that build the quantised quarter-wave cosine table.
package twiddle_pkg;

    localparam logic FMT_FP8 = 1'b1;
    localparam logic FMT_FP4 = 1'b0;
    localparam int FP8_SIGN = 7;
    localparam int FP4_SIGN = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_t;

    localparam longint ONE_Q30 = 64'sd1 << 30;
    localparam longint PI_Q30  = 64'sd3373259426;

    // cos(2*pi*i/max_n) in Q30 for angles up to pi/2, by Taylor series.
    function automatic longint cos_q30(input int i, input int max_n);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (2 * PI_Q30 * i) / max_n;
        x2   = (x * x) >>> 30;
        term = ONE_Q30;
        sum  = term;
        for (int n = 1; n <= 12; n++) begin
            term = -((term * x2) >>> 30) / ((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        if (sum < 0)
            sum = 0;
        if (sum > ONE_Q30)
            sum = ONE_Q30;
        return sum;
    endfunction

    function automatic longint rne_shift(input longint v, input int sh);
        longint q;
        longint rem;
        longint half;
        q    = v >>> sh;
        rem  = v - (q << sh);
        half = 64'sd1 << (sh - 1);
        if (rem > half || (rem == half && q[0]))
            q = q + 1;
        return q;
    endfunction

    // E4M3 magnitude of a Q30 value in [0,1]; a mantissa carry rolls into the exponent.
    function automatic logic [7:0] quant_fp8(input longint v);
        int p;
        logic [7:0] r;
        p = 0;
        for (int j = 0; j <= 30; j++)
            if (v[j])
                p = j;
        if (v <= 0)
            r = 8'h00;
        else if (p < 24)
            r = 8'(rne_shift(v, 21));
        else
            r = 8'(((p - 24) << 3) + rne_shift(v, p - 3));
        return r;
    endfunction

    // E2M1 magnitude of a Q30 value in [0,1]: half-unit steps up to 1.0.
    function automatic logic [3:0] quant_fp4(input longint v);
        logic [3:0] r;
        if (v <= 0)
            r = 4'h0;
        else
            r = 4'(rne_shift(v, 29));
        return r;
    endfunction

    // Toggle the sign only for a nonzero magnitude so zero stays +0.
    function automatic logic [7:0] neg_zero(input logic [7:0] x, input int sign_pos, input logic neg);
        logic [7:0] mag_mask;
        logic [7:0] r;
        mag_mask = (8'd1 << sign_pos) - 8'd1;
        r = x;
        if (neg && ((x & mag_mask) != 8'h00))
            r = x ^ (8'd1 << sign_pos);
        return r;
    endfunction

endpackage

// File: rtl/twiddle_quarter_rom.sv
// Quarter-wave cosine magnitudes {E4M3, E2M1}, two registered read ports.
module twiddle_quarter_rom
    import twiddle_pkg::*;
#(
    parameter int MAX_N = 64,
    parameter int AW    = $clog2(MAX_N) - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [AW-1:0] addr_re,
    input  logic [AW-1:0] addr_im,
    output logic [11:0]   data_re,
    output logic [11:0]   data_im
);

    localparam int Q = MAX_N / 4;

    logic [11:0] rom [0:Q];

    for (genvar i = 0; i <= Q; i++) begin : g_tab
        localparam longint C = cos_q30(i, MAX_N);
        assign rom[i] = {quant_fp8(C), quant_fp4(C)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_re <= '0;
            data_im <= '0;
        end else if (en) begin
            data_re <= rom[addr_re];
            data_im <= rom[addr_im];
        end
    end

endmodule

// File: rtl/twiddle_sequencer.sv
// Streams radix-2 DIT twiddle factors W_N^k stage by stage for N = 2..MAX_N,
// using a quarter-wave table and quadrant symmetry, as FP8 or FP4.
module twiddle_sequencer
    import twiddle_pkg::*;
#(
    parameter int MAX_N    = 64,
    parameter int LOG2_MAX = $clog2(MAX_N),
    parameter int LW       = $clog2(LOG2_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LW-1:0]       log2_n,
    input  logic                fmt,
    output logic                busy,
    output logic                err,
    output logic                tw_valid,
    input  logic                tw_ready,
    output logic [15:0]         tw_data,
    output logic [LW-1:0]       tw_stage,
    output logic [LOG2_MAX-2:0] tw_index,
    output logic                tw_last,
    output logic                done
);

    localparam int KW = LOG2_MAX - 1;
    localparam int Q  = MAX_N / 4;

    state_t state, state_nx;

    logic [LW-1:0] l_len;
    logic          fmt_q;
    logic [LW-1:0] s_cnt;
    logic [KW-1:0] b_cnt;
    logic [KW-1:0] b_max;
    logic [KW-1:0] mask;
    logic [KW-1:0] k_cur;
    logic [LW-1:0] sh;
    logic          advance;
    logic          issue;
    logic          word_last;
    logic          start_ok;
    logic          accept;
    logic          last_hs;

    logic          vld_p1;
    logic          last_p1;
    logic          quad_p1;
    logic [KW-1:0] k_p1;
    logic [KW-1:0] b_p1;
    logic [LW-1:0] s_p1;
    logic [KW-1:0] addr_re;
    logic [KW-1:0] addr_im;
    logic [11:0]   mag_re_p2;
    logic [11:0]   mag_im_p2;
    logic          quad_p2;

    // Whole pipeline moves together: it advances unless the output word is stalled.
    assign advance   = !tw_valid || tw_ready;
    assign issue     = (state == ST_RUN) && advance;
    assign start_ok  = (log2_n != '0) && (log2_n <= LW'(LOG2_MAX));
    assign accept    = (state == ST_IDLE) && start && start_ok;
    assign last_hs   = tw_valid && tw_ready && tw_last;
    assign b_max     = (KW'(1) << (l_len - LW'(1))) - KW'(1);
    assign word_last = (s_cnt == l_len - LW'(1)) && (b_cnt == b_max);
    assign mask      = (KW'(1) << s_cnt) - KW'(1);
    assign sh        = LW'(KW) - s_cnt;
    assign k_cur     = (b_cnt & mask) << sh;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = ST_RUN;
            ST_RUN:   if (issue && word_last) state_nx = ST_FLUSH;
            ST_FLUSH: if (last_hs) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_len <= '0;
            fmt_q <= FMT_FP4;
            s_cnt <= '0;
            b_cnt <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            err  <= (state == ST_IDLE) && start && !start_ok;
            done <= (state == ST_FLUSH) && last_hs;
            if (accept) begin
                l_len <= log2_n;
                fmt_q <= fmt;
                s_cnt <= '0;
                b_cnt <= '0;
            end else if (issue && !word_last) begin
                if (b_cnt == b_max) begin
                    b_cnt <= '0;
                    s_cnt <= s_cnt + LW'(1);
                end else begin
                    b_cnt <= b_cnt + KW'(1);
                end
            end
        end
    end

    // P1: angle index, quadrant and word tags
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (advance)
            vld_p1 <= (state == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            k_p1    <= k_cur;
            quad_p1 <= (k_cur > KW'(Q));
            s_p1    <= s_cnt;
            b_p1    <= b_cnt;
            last_p1 <= word_last;
        end
    end

    // Second quadrant reflects about Q: real = -C[Q-k'], imag = -C[k'], k' = k-Q.
    assign addr_re = quad_p1 ? (KW'(Q) - (k_p1 - KW'(Q))) : k_p1;
    assign addr_im = quad_p1 ? (k_p1 - KW'(Q)) : (KW'(Q) - k_p1);

    // P2: table read and output word
    twiddle_quarter_rom #(
        .MAX_N (MAX_N),
        .AW    (KW)
    ) u_rom (
        .clk     (clk),
        .rst     (rst),
        .en      (advance && vld_p1),
        .addr_re (addr_re),
        .addr_im (addr_im),
        .data_re (mag_re_p2),
        .data_im (mag_im_p2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tw_valid <= 1'b0;
            tw_stage <= '0;
            tw_index <= '0;
            tw_last  <= 1'b0;
            quad_p2  <= 1'b0;
        end else if (advance) begin
            tw_valid <= vld_p1;
            tw_last  <= vld_p1 && last_p1;
            if (vld_p1) begin
                tw_stage <= s_p1;
                tw_index <= b_p1;
                quad_p2  <= quad_p1;
            end
        end
    end

    always_comb begin
        tw_data = '0;
        if (fmt_q == FMT_FP8)
            tw_data = {neg_zero(mag_re_p2[11:4], FP8_SIGN, quad_p2),
                       neg_zero(mag_im_p2[11:4], FP8_SIGN, 1'b1)};
        else
            tw_data = {8'h00,
                       4'(neg_zero({4'h0, mag_re_p2[3:0]}, FP4_SIGN, quad_p2)),
                       4'(neg_zero({4'h0, mag_im_p2[3:0]}, FP4_SIGN, 1'b1))};
    end

endmodule

// File: tb/tb_twiddle_sequencer.sv
// Scoreboard bench for twiddle_sequencer: stimulus queues expected words from a
// real-arithmetic model; a negedge monitor pops and compares on each handshake.
module tb_twiddle_sequencer;

    localparam int  MAX_N    = 64;
    localparam int  LOG2_MAX = $clog2(MAX_N);
    localparam int  LW       = $clog2(LOG2_MAX + 1);
    localparam real PI       = 3.14159265358979323846;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [LW-1:0]       log2_n = '0;
    logic                fmt = 1'b0;
    logic                tw_ready = 1'b1;
    logic                busy, err, tw_valid, tw_last, done;
    logic [15:0]         tw_data;
    logic [LW-1:0]       tw_stage;
    logic [LOG2_MAX-2:0] tw_index;

    typedef struct {
        logic [15:0] data;
        int          stage;
        int          index;
        bit          last;
    } exp_t;

    exp_t exp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_count = 0;
    int   last_hs_cyc = -10;
    bit   rand_ready = 1'b0;

    twiddle_sequencer #(.MAX_N(MAX_N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .log2_n   (log2_n),
        .fmt      (fmt),
        .busy     (busy),
        .err      (err),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready),
        .tw_data  (tw_data),
        .tw_stage (tw_stage),
        .tw_index (tw_index),
        .tw_last  (tw_last),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: nearest representable value by exhaustive search, ties to even code.
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real decode(input int c, input bit f8);
        int e, m;
        if (f8) begin
            e = c >> 3; m = c & 7;
            return (e == 0) ? (m / 8.0) * pow2(-6) : (1.0 + m / 8.0) * pow2(e - 7);
        end
        e = c >> 1; m = c & 1;
        return (e == 0) ? m * 0.5 : (1.0 + m * 0.5) * pow2(e - 1);
    endfunction

    function automatic int nearest(input real v, input bit f8);
        int  best = 0;
        real bd = 1.0e30;
        real d;
        for (int c = 0; c < (f8 ? 127 : 8); c++) begin
            d = decode(c, f8) - v;
            if (d < 0.0) d = -d;
            if (d < bd || (d == bd && (c % 2) == 0)) begin
                bd = d;
                best = c;
            end
        end
        return best;
    endfunction

    function automatic logic [15:0] model_word(input int k, input bit f8);
        real th, c, sn;
        int  rc, ic;
        bit  rn, in_;
        th  = 2.0 * PI * k / MAX_N;
        c   = $cos(th);
        sn  = $sin(th);
        rc  = nearest((c < 0.0) ? -c : c, f8);
        ic  = nearest((sn < 0.0) ? -sn : sn, f8);
        rn  = (c < 0.0) && (rc != 0);
        in_ = (ic != 0);
        if (f8) return {rn, 7'(rc), in_, 7'(ic)};
        return {8'h00, rn, 3'(rc), in_, 3'(ic)};
    endfunction

    task automatic push_model_run(input int l, input bit f8);
        exp_t e;
        int   nb = 1 << (l - 1);
        for (int s = 0; s < l; s++) begin
            for (int b = 0; b < nb; b++) begin
                e.data  = model_word((b % (1 << s)) * (MAX_N >> (s + 1)), f8);
                e.stage = s;
                e.index = b;
                e.last  = (s == l - 1) && (b == nb - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_const(input logic [15:0] d, input int s, input int b, input bit last);
        exp_t e;
        e.data = d; e.stage = s; e.index = b; e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input int l, input bit f);
        @(posedge clk); #1;
        start = 1'b1; log2_n = LW'(l); fmt = f;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout actual=none required=done_within_%0d", budget);
        end
        check("busy_at_done", busy, 0);
        check("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk); #1;
        tw_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: handshake scoreboard, stall stability, done timing.
    initial begin : monitor
        exp_t       e;
        bit         prev_stall = 1'b0;
        logic [24:0] prev_word = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", tw_valid, 1);
                    check("stall_word", {tw_data, tw_stage, tw_index, tw_last}, prev_word);
                end
                if (done) check("done_timing", cyc, last_hs_cyc + 1);
                if (tw_valid && tw_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_word actual=%h required=none", tw_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", tw_data, e.data);
                        check("word_stage", tw_stage, e.stage);
                        check("word_index", tw_index, e.index);
                        check("word_last", tw_last, e.last);
                    end
                    hs_count++;
                    if (tw_last) last_hs_cyc = cyc;
                end
                prev_stall = tw_valid && !tw_ready;
                prev_word  = {tw_data, tw_stage, tw_index, tw_last};
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    localparam logic [15:0] FIX8 [12] = '{16'h3800, 16'h3800, 16'h3800, 16'h3800,
                                          16'h3800, 16'h00B8, 16'h3800, 16'h00B8,
                                          16'h3800, 16'h33B3, 16'h00B8, 16'hB3B3};
    localparam logic [15:0] FIX4 [4]  = '{16'h0020, 16'h0020, 16'h0020, 16'h000A};

    initial begin : main
        int  base;
        bit  seen;
        int  bad [2] = '{0, 7};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", tw_valid, 0);
        check("rst_data", tw_data, 0);
        check("rst_ctrl", {busy, err, done, tw_last}, 0);
        rst = 1'b0;

        // Known N=8 FP8 sequence with ready held high, including latency.
        rand_ready = 1'b0;
        for (int i = 0; i < 12; i++) push_const(FIX8[i], i / 4, i % 4, i == 11);
        pulse_start(3, 1'b1);
        check("busy_after_start", busy, 1);
        check("lat_t0", tw_valid, 0);
        @(posedge clk); #1;
        check("lat_t1", tw_valid, 0);
        @(posedge clk); #1;
        check("lat_t2", tw_valid, 1);
        wait_done(100);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);

        // Same run under random backpressure, against the model.
        rand_ready = 1'b1;
        push_model_run(3, 1'b1);
        pulse_start(3, 1'b1);
        wait_done(400);

        // N = 2: single word.
        rand_ready = 1'b0;
        push_const(16'h3800, 0, 0, 1'b1);
        pulse_start(1, 1'b1);
        wait_done(50);

        // Out-of-range sizes are rejected.
        foreach (bad[j]) begin
            pulse_start(bad[j], 1'b1);
            check("err_pulse", err, 1);
            check("err_busy", busy, 0);
            @(posedge clk); #1;
            check("err_once", err, 0);
            repeat (3) @(posedge clk);
            #1;
            check("err_no_valid", {tw_valid, busy}, 0);
        end

        // FP4, N = 4.
        for (int i = 0; i < 4; i++) push_const(FIX4[i], i / 2, i % 2, i == 3);
        pulse_start(2, 1'b0);
        wait_done(50);

        // Reset in the middle of a run, then a clean rerun.
        push_model_run(3, 1'b1);
        base = hs_count;
        pulse_start(3, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (hs_count >= base + 4) begin seen = 1'b1; break; end
        end
        check("mid_run_reached", seen, 1);
        #1; rst = 1'b1;
        #1;
        check("mid_rst_valid", tw_valid, 0);
        check("mid_rst_data", tw_data, 0);
        check("mid_rst_ctrl", {busy, err, done, tw_last}, 0);
        check("mid_rst_tag", {tw_stage, tw_index}, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_word_after_rst", {tw_valid, busy}, 0);
        push_model_run(3, 1'b1);
        pulse_start(3, 1'b1);
        wait_done(100);

        // start while busy is ignored.
        rand_ready = 1'b1;
        push_model_run(3, 1'b1);
        pulse_start(3, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; log2_n = LW'(2); fmt = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start_err", err, 0);
        check("busy_start_busy", busy, 1);
        wait_done(400);

        // Random sizes and formats under random backpressure.
        for (int r = 0; r < 6; r++) begin
            int  l = $urandom_range(1, LOG2_MAX);
            bit  f = 1'($urandom_range(0, 1));
            push_model_run(l, f);
            pulse_start(l, f);
            wait_done(4000);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
